// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and funct codes for the ALU decoder and the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_XOR  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    // Encoding matches funct[1:0] of the mult/div group
    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } mdu_op_t;

    localparam logic [5:0] C_FN_SLL   = 6'b000000;
    localparam logic [5:0] C_FN_SRL   = 6'b000010;
    localparam logic [5:0] C_FN_SRA   = 6'b000011;
    localparam logic [5:0] C_FN_ADD   = 6'b100000;
    localparam logic [5:0] C_FN_ADDU  = 6'b100001;
    localparam logic [5:0] C_FN_SUB   = 6'b100010;
    localparam logic [5:0] C_FN_SUBU  = 6'b100011;
    localparam logic [5:0] C_FN_AND   = 6'b100100;
    localparam logic [5:0] C_FN_OR    = 6'b100101;
    localparam logic [5:0] C_FN_XOR   = 6'b100110;
    localparam logic [5:0] C_FN_NOR   = 6'b100111;
    localparam logic [5:0] C_FN_SLT   = 6'b101010;
    localparam logic [5:0] C_FN_SLTU  = 6'b101011;
    localparam logic [5:0] C_FN_MULT  = 6'b011000;
    localparam logic [5:0] C_FN_MULTU = 6'b011001;
    localparam logic [5:0] C_FN_DIV   = 6'b011010;
    localparam logic [5:0] C_FN_DIVU  = 6'b011011;
    localparam logic [5:0] C_FN_MFHI  = 6'b010000;
    localparam logic [5:0] C_FN_MTHI  = 6'b010001;
    localparam logic [5:0] C_FN_MFLO  = 6'b010010;
    localparam logic [5:0] C_FN_MTLO  = 6'b010011;

    // R-type funct to ALU operation; unknown functs fall back to add
    function automatic alu_op_t decode_funct(input logic [5:0] fn);
        case (fn)
            C_FN_SLL:             return ALU_SLL;
            C_FN_SRL:             return ALU_SRL;
            C_FN_SRA:             return ALU_SRA;
            C_FN_ADD, C_FN_ADDU:  return ALU_ADD;
            C_FN_SUB, C_FN_SUBU:  return ALU_SUB;
            C_FN_AND:             return ALU_AND;
            C_FN_OR:              return ALU_OR;
            C_FN_XOR:             return ALU_XOR;
            C_FN_NOR:             return ALU_NOR;
            C_FN_SLT:             return ALU_SLT;
            C_FN_SLTU:            return ALU_SLTU;
            default:              return ALU_ADD;
        endcase
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative shift-add multiplier / restoring divider, one bit
//               per cycle, with sign fix-up. start_i loads operands; done_o
//               is high in the last iteration cycle, when hi_o/lo_o hold the
//               final result to be captured on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  mdu_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    // acc_q: multiply -> {partial high, multiplier shifting out}
    //        divide   -> {remainder, dividend shifting into quotient}
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opd_q;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_q;       // raw dividend, returned as HI on divide by zero
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic               is_div_q;
    logic               neg_q;     // product/quotient negative
    logic               rneg_q;    // remainder negative
    logic               dz_q;

    logic               w_is_div;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;

    assign w_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign w_sgn    = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign w_mag_a  = (w_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_mag_b  = (w_sgn && b_i[WIDTH-1]) ? -b_i : b_i;
    assign done_o   = run_q && (cnt_q == CW'(WIDTH - 1));

    // One multiply or divide iteration on the accumulator
    always_comb begin
        w_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_q[0] ? opd_q : {WIDTH{1'b0}})};
        w_shift = acc_q[2*WIDTH-1:WIDTH-1];
        w_diff  = w_shift - {1'b0, opd_q};
        if (is_div_q) begin
            if (w_diff[WIDTH]) begin
                w_step = {w_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                w_step = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_step = {w_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final iteration, plus divide-by-zero override
    always_comb begin
        w_prod = neg_q ? -w_step : w_step;
        if (!is_div_q) begin
            hi_o = w_prod[2*WIDTH-1:WIDTH];
            lo_o = w_prod[WIDTH-1:0];
        end else if (dz_q) begin
            hi_o = a_q;
            lo_o = {WIDTH{1'b1}};
        end else begin
            hi_o = rneg_q ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
            lo_o = neg_q  ? -w_step[WIDTH-1:0]       : w_step[WIDTH-1:0];
        end
    end

    // Operand capture on start, then one iteration per cycle until done
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            opd_q    <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else if (start_i) begin
            acc_q    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            opd_q    <= w_is_div ? w_mag_b : w_mag_a;
            a_q      <= a_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
            is_div_q <= w_is_div;
            neg_q    <= w_sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q   <= w_sgn && a_i[WIDTH-1];
            dz_q     <= (b_i == '0);
        end else if (run_q) begin
            acc_q <= w_step;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule : mdu_iter
`default_nettype wire

// File: rtl/alu_mdu_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_control
// Description : MIPS ALU control decoder with HI/LO registers and an
//               iterative multiply/divide unit that stalls the pipeline while
//               an operation is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_control
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [1:0]       aluop,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic             result_sel,
    output logic [WIDTH-1:0] mdu_result,
    output logic             stall,
    output logic             busy
);

    mdu_state_t       state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             w_is_r, w_muldiv, w_mfhi, w_mflo, w_mthi, w_mtlo, w_mfmt;
    logic             w_start, w_mt_ok, w_done;
    logic [WIDTH-1:0] w_mdu_hi, w_mdu_lo;
    alu_op_t          w_aluop;

    assign w_is_r   = (aluop == 2'b10);
    assign w_muldiv = w_is_r && (funct inside {C_FN_MULT, C_FN_MULTU, C_FN_DIV, C_FN_DIVU});
    assign w_mfhi   = w_is_r && (funct == C_FN_MFHI);
    assign w_mflo   = w_is_r && (funct == C_FN_MFLO);
    assign w_mthi   = w_is_r && (funct == C_FN_MTHI);
    assign w_mtlo   = w_is_r && (funct == C_FN_MTLO);
    assign w_mfmt   = w_mfhi || w_mflo || w_mthi || w_mtlo;

    assign busy     = (state_q != ST_IDLE);
    assign w_start  = (state_q == ST_IDLE) && valid && w_muldiv;
    // DONE lets the held instruction retire, so it never stalls
    assign stall    = w_start
                   || (state_q == ST_BUSY)
                   || (valid && busy && w_mfmt && (state_q != ST_DONE));
    assign w_mt_ok  = valid && !stall;

    // ALU operation select; independent of valid
    always_comb begin
        w_aluop = ALU_ADD;
        case (aluop)
            2'b01:   w_aluop = ALU_SUB;
            2'b10:   w_aluop = decode_funct(funct);
            default: w_aluop = ALU_ADD;
        endcase
    end
    assign alucontrol = w_aluop;

    // HI/LO read-out for mfhi/mflo
    always_comb begin
        result_sel = w_mfhi || w_mflo;
        mdu_result = '0;
        if (w_mfhi) begin
            mdu_result = hi_q;
        end else if (w_mflo) begin
            mdu_result = lo_q;
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu_iter (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_start),
        .op_i    (mdu_op_t'(funct[1:0])),
        .a_i     (srca),
        .b_i     (srcb),
        .done_o  (w_done),
        .hi_o    (w_mdu_hi),
        .lo_o    (w_mdu_lo)
    );

    // Next-state logic: issue, iterate, one retire cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start) state_d = ST_BUSY;
            ST_BUSY: if (w_done)  state_d = ST_DONE;
            ST_DONE:              state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HI/LO: MDU result on completion, otherwise mthi/mtlo writes
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (w_done) begin
            hi_q <= w_mdu_hi;
            lo_q <= w_mdu_lo;
        end else begin
            if (w_mt_ok && w_mthi) hi_q <= srca;
            if (w_mt_ok && w_mtlo) lo_q <= srca;
        end
    end

endmodule : alu_mdu_control
`default_nettype wire

// File: tb/tb_alu_mdu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu_control
// Description : Self-checking bench for alu_mdu_control (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_control;

    localparam int C_W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           valid;
    logic [5:0]     funct;
    logic [1:0]     aluop;
    logic [C_W-1:0] srca, srcb;
    logic [3:0]     alucontrol;
    logic           result_sel;
    logic [C_W-1:0] mdu_result;
    logic           stall, busy;

    int checks = 0;
    int errors = 0;

    alu_mdu_control #(.WIDTH(C_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .funct      (funct),
        .aluop      (aluop),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .result_sel (result_sel),
        .mdu_result (mdu_result),
        .stall      (stall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from plain arithmetic on the architectural rules
    function automatic logic [63:0] ref_mdu(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (fn)
            6'b011000: return 64'(sa * sb);
            6'b011001: return ua * ub;
            6'b011010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(a % b), 32'(a / b)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue mult/div, count stall cycles, then read HI and LO with mfhi/mflo
    task automatic run_mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        exp   = ref_mdu(fn, a, b);
        valid = 1'b1; aluop = 2'b10; funct = fn; srca = a; srcb = b;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 100) begin
            tick();
            srca = $urandom; srcb = $urandom;
            #1;
            n++;
        end
        chk($sformatf("stall_len f=%b", fn), 64'(n), 64'd33);
        chk("busy_in_done", {63'b0, busy}, 64'd1);
        tick();
        funct = 6'b010000;
        #1;
        chk($sformatf("hi f=%b a=%h b=%h", fn, a, b), {32'b0, mdu_result}, {32'b0, exp[63:32]});
        chk("mfhi_nostall", {63'b0, stall}, 64'd0);
        tick();
        funct = 6'b010010;
        #1;
        chk($sformatf("lo f=%b a=%h b=%h", fn, a, b), {32'b0, mdu_result}, {32'b0, exp[31:0]});
        chk("mflo_sel", {63'b0, result_sel}, 64'd1);
        tick();
        valid = 1'b0; aluop = 2'b00;
    endtask

    initial begin
        int exp_tab [64];
        logic [5:0]  fn;
        logic [31:0] a, b, v;
        logic [63:0] exp;
        int n;

        // Reset
        reset = 1'b1; valid = 1'b0; aluop = 2'b00; funct = '0; srca = '0; srcb = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_sel", {63'b0, result_sel}, 64'd0);
        chk("rst_result", {32'b0, mdu_result}, 64'd0);
        chk("rst_aluctl", {60'b0, alucontrol}, 64'd0);

        // Funct sweep
        for (int i = 0; i < 64; i++) exp_tab[i] = 0;
        exp_tab[6'b000000] = 6;  exp_tab[6'b000010] = 7;  exp_tab[6'b000011] = 9;
        exp_tab[6'b100000] = 0;  exp_tab[6'b100001] = 0;
        exp_tab[6'b100010] = 1;  exp_tab[6'b100011] = 1;
        exp_tab[6'b100100] = 2;  exp_tab[6'b100101] = 3;
        exp_tab[6'b100110] = 8;  exp_tab[6'b100111] = 4;
        exp_tab[6'b101010] = 5;  exp_tab[6'b101011] = 10;
        aluop = 2'b10;
        for (int i = 0; i < 64; i++) begin
            funct = 6'(i);
            #1;
            chk($sformatf("aluctl f=%b", funct), {60'b0, alucontrol}, 64'(exp_tab[i]));
        end
        funct = 6'b100010;
        aluop = 2'b00; #1; chk("aluop00", {60'b0, alucontrol}, 64'd0);
        aluop = 2'b01; #1; chk("aluop01", {60'b0, alucontrol}, 64'd1);
        aluop = 2'b11; #1; chk("aluop11", {60'b0, alucontrol}, 64'd0);
        chk("idle_no_stall", {63'b0, stall}, 64'd0);
        aluop = 2'b00;
        tick();

        // Directed arithmetic corner cases
        run_mdu(6'b011000, 32'hFFFF_FFFD, 32'd7);
        run_mdu(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mdu(6'b011010, 32'hFFFF_FFF9, 32'd2);
        run_mdu(6'b011011, 32'd7, 32'd0);
        run_mdu(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mdu(6'b011010, 32'h8000_0005, 32'd0);

        // Randomized operations
        for (int k = 0; k < 12; k++) begin
            fn = 6'b011000 | 6'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            run_mdu(fn, a, b);
        end

        // mflo presented while busy
        a = $urandom; b = $urandom;
        exp = ref_mdu(6'b011001, a, b);
        valid = 1'b1; aluop = 2'b10; funct = 6'b011001; srca = a; srcb = b;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 100) begin
            tick();
            if (n == 4) funct = 6'b010010;
            #1;
            n++;
        end
        chk("mflo_busy_len", 64'(n), 64'd33);
        chk("mflo_busy_sel", {63'b0, result_sel}, 64'd1);
        chk("mflo_busy_val", {32'b0, mdu_result}, {32'b0, exp[31:0]});
        tick();
        chk("mflo_after_idle", {63'b0, busy}, 64'd0);
        valid = 1'b0; aluop = 2'b00;
        tick();

        // mthi / mtlo round trip
        valid = 1'b1; aluop = 2'b10; funct = 6'b010001; srca = 32'h1234;
        #1;
        chk("mthi_nostall", {63'b0, stall}, 64'd0);
        tick();
        v = $urandom;
        funct = 6'b010011; srca = v;
        tick();
        funct = 6'b010000; srca = 32'hDEAD_BEEF;
        #1;
        chk("mthi_mfhi", {32'b0, mdu_result}, 64'h1234);
        funct = 6'b010010;
        #1;
        chk("mtlo_mflo", {32'b0, mdu_result}, {32'b0, v});
        tick();

        // Reset aborts an in-flight operation
        funct = 6'b011000; srca = 32'd9; srcb = 32'd9;
        for (int i = 0; i < 11; i++) tick();
        chk("pre_abort_busy", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; valid = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_stall", {63'b0, stall}, 64'd0);
        valid = 1'b1; aluop = 2'b10; funct = 6'b010000;
        #1;
        chk("abort_hi", {32'b0, mdu_result}, 64'd0);
        chk("abort_mf_stall", {63'b0, stall}, 64'd0);
        funct = 6'b010010;
        #1;
        chk("abort_lo", {32'b0, mdu_result}, 64'd0);
        tick();
        run_mdu(6'b011001, 32'd3, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_mdu_control
`default_nettype wire

// File: doc/alu_mdu_control.md
# alu_mdu_control

Parametrised successor to the combinational MIPS ALU decoder. It decodes `aluop`/`funct` into a 4-bit ALU operation, adding `xor`, `sra` and `sltu`. It also owns the HI/LO registers and an iterative multiply/divide unit (MDU) for `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo`. It sits in the execute stage beside the ALU and stalls the pipeline while a multicycle operation is outstanding.

## Interface
- `WIDTH`, default 32: datapath width. Even, ≥4.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `valid`  in  1: an instruction is present in execute.
- `funct`  in  6: instruction bits [5:0].
- `aluop`  in  2: control from the main decoder.
- `srca`  in  WIDTH: rs operand.
- `srcb`  in  WIDTH: rt operand.
- `alucontrol`  out  4: ALU operation code.
- `result_sel`  out  1: 1 = datapath writes `mdu_result` instead of the ALU result.
- `mdu_result`  out  WIDTH: HI (`mfhi`) or LO (`mflo`).
- `stall`  out  1: hold fetch/decode/execute this cycle.
- `busy`  out  1: FSM not IDLE.

## Operation
**ALU codes**
- 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt, 6 sll, 7 srl, 8 xor, 9 sra, 10 sltu.
- `aluop` 00 → 0; 01 → 1; 11 → 0.
- `aluop` 10 decodes `funct`:
  - 000000 → 6, 000010 → 7, 000011 → 9
  - 100000/100001 → 0, 100010/100011 → 1
  - 100100 → 2, 100101 → 3, 100110 → 8, 100111 → 4
  - 101010 → 5, 101011 → 10
  - any other funct → 0.
- `alucontrol` is purely combinational and is driven even when `valid`=0.

**MDU functs (only when `aluop`=10)**
- 011000 mult, 011001 multu, 011010 div, 011011 divu.
- 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.

**FSM: IDLE, BUSY, DONE**
- IDLE → BUSY: `valid` and a mult/div funct. Captures operands, op and signedness; counter ← 0.
- BUSY → DONE: after WIDTH iterations (counter = WIDTH−1). HI/LO are written on that edge.
- DONE → IDLE: unconditionally. A mult/div seen in DONE is not re-issued.

**Arithmetic**
- Multiply: shift-add, one bit per cycle. {HI,LO} = full 2·WIDTH product.
- Divide: restoring, one bit per cycle. LO = quotient, HI = remainder.
- Signed ops operate on magnitudes, then apply signs: product/quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide by zero: full latency still taken; LO = all ones, HI = `srca`; no exception.
- Signed MIN/−1: LO = MIN, HI = 0.

**mthi/mtlo and mfhi/mflo**
- mthi/mtlo: HI/LO ← `srca` on the edge of a cycle with `valid` & !`stall`.
- mfhi/mflo: `result_sel`=1 and `mdu_result` = HI/LO combinationally.
- Neither may proceed while `busy` (interlock stall).

**Stall**
- `stall` = (IDLE & `valid` & mult/div) | BUSY | (`valid` & `busy` & mf/mt funct in IDLE/BUSY).
- `stall` is 0 in DONE.

## Timing
- Reset values:
  - State IDLE, HI = LO = 0, counter = 0.
  - `stall` = 0, `busy` = 0, `result_sel` = 0, `mdu_result` = 0, `alucontrol` = 0 (with `valid`=0, `aluop`=00).
- Mult/div issued in cycle 0: `stall`=1 in cycles 0..WIDTH (WIDTH+1 cycles).
- New HI/LO are visible in cycle WIDTH+1 (DONE). The held instruction retires there with `stall`=0.
- An mfhi directly after a mult gets the new HI with no extra stall beyond the above.
- Reset asserted mid-operation aborts the operation: next cycle IDLE, HI/LO = 0, `stall`=0.
- Operand changes after issue are ignored; operands are latched in the start cycle.

## Structure
- `alu_pkg`: `alu_op_t` (4-bit enum above), funct localparams, `mdu_state_t` {IDLE, BUSY, DONE}, `mdu_op_t` {MULT, MULTU, DIV, DIVU}.
- Sub-module `mdu_iter` (WIDTH parameter) holds the multiply/divide shift registers and the sign fix-up. It has a start/done pulse interface.
- Decode, FSM and HI/LO live in `alu_mdu_control`.

## Test plan
- Full funct sweep, `aluop`=10: every listed code matches; 000001, 111111 → 0. `aluop` 00/01/11 → 0/1/0.
- `mult` with −3 × 7 (WIDTH=32): `stall` high 33 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. `multu` 0xFFFFFFFF²: HI = 0xFFFFFFFE, LO = 0x00000001.
- `div` with −7/2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. `divu` 7/0: LO = 0xFFFFFFFF, HI = 7. `div` 0x80000000/−1: LO = 0x80000000, HI = 0.
- `mflo` presented during BUSY: stall holds until DONE, then `mdu_result` = new LO with `result_sel`=1. `mthi` 0x1234 in IDLE, then `mfhi` → 0x1234.
- Reset asserted at BUSY cycle 10: next cycle `busy`=0, `stall`=0, HI = LO = 0. A following `multu` 3×5 gives LO = 15.
